fft_cbfp_exp_calc: RTL and testbench

Parametrised CBFP block-exponent calculator for the FFT datapath. It takes LANES complex samples per valid beat and groups BLOCK_BEATS beats into one CBFP block. For each block it finds the minimum leading-sign count over all real and imaginary values and emits a clamped shift exponent. It also keeps a history of the last HIST_DEPTH exponents for the downstream normaliser.

---
 rtl/fft_cbfp_exp_calc.sv | 96 +++++++++
 tb/tb_fft_cbfp_exp_calc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_cbfp_exp_calc.sv
// fft_cbfp_exp_calc: CBFP block exponent (min leading-sign count) with clamp and history
module fft_cbfp_exp_calc #(
  parameter int DIN_W       = 23,
  parameter int LANES       = 16,
  parameter int BLOCK_BEATS = 4,
  parameter int HIST_DEPTH  = 4,
  parameter int MAX_SHIFT   = 12,
  parameter int EXP_W       = $clog2(DIN_W)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_in,
  input  logic                                flush,
  input  logic [LANES-1:0][DIN_W-1:0]         din_re,
  input  logic [LANES-1:0][DIN_W-1:0]         din_im,
  output logic                                exp_valid,
  output logic [EXP_W-1:0]                    exp_out,
  output logic [EXP_W-1:0]                    exp_raw,
  output logic [HIST_DEPTH-1:0][EXP_W-1:0]    exp_hist,
  output logic [15:0]                         blk_cnt,
  output logic                                busy
);
  localparam int CNT_W = BLOCK_BEATS > 1 ? $clog2(BLOCK_BEATS) : 1;
  localparam logic [EXP_W-1:0] MAX_E = EXP_W'(MAX_SHIFT);
  logic [CNT_W-1:0] cnt;
  logic             s1_valid, s1_last, s1_first, last_beat;
  logic [EXP_W-1:0] s1_min, beat_min, acc, blk_min, blk_clamp;
  function automatic logic [EXP_W-1:0] lsc(input logic [DIN_W-1:0] x);
    logic run;
    lsc = '0;
    run = 1'b1;
    for (int i = DIN_W-2; i >= 0; i--) begin
      run = run & (x[i] == x[DIN_W-1]);
      lsc = lsc + EXP_W'(run);
    end
  endfunction
  // minimum leading-sign count across every real and imaginary lane of the beat
  always_comb begin
    beat_min = EXP_W'(DIN_W-1);
    for (int l = 0; l < LANES; l++) begin
      beat_min = lsc(din_re[l]) < beat_min ? lsc(din_re[l]) : beat_min;
      beat_min = lsc(din_im[l]) < beat_min ? lsc(din_im[l]) : beat_min;
    end
  end
  assign last_beat = cnt == CNT_W'(BLOCK_BEATS-1);
  assign blk_min   = (s1_first || s1_min < acc) ? s1_min : acc;
  assign blk_clamp = blk_min > MAX_E ? MAX_E : blk_min;
  assign busy      = (cnt != '0) || (s1_valid && !s1_last);
  // stage 1: register the beat minimum and track the position within the block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_min   <= '0;
    end else if (flush) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_min   <= beat_min;
        s1_last  <= last_beat;
        s1_first <= cnt == '0;
        cnt      <= last_beat ? '0 : cnt + 1'b1;
      end
    end
  end
  // stage 2: fold beats into the block minimum and publish it on the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      exp_valid <= 1'b0;
      exp_out   <= '0;
      exp_raw   <= '0;
      exp_hist  <= '0;
      blk_cnt   <= '0;
    end else begin
      exp_valid <= 1'b0;
      if (flush) begin
        acc <= '0;
      end else if (s1_valid) begin
        acc <= blk_min;
        if (s1_last) begin
          exp_raw   <= blk_min;
          exp_out   <= blk_clamp;
          exp_valid <= 1'b1;
          blk_cnt   <= blk_cnt + 16'd1;
          exp_hist[0] <= blk_clamp;
          for (int i = HIST_DEPTH-1; i > 0; i--) exp_hist[i] <= exp_hist[i-1];
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_cbfp_exp_calc.sv
// tb_fft_cbfp_exp_calc: table-driven scoreboard bench for the CBFP exponent calculator
module tb_fft_cbfp_exp_calc;
  localparam int DIN_W = 23, LANES = 16, BB = 4, HD = 4, MS = 12;
  localparam int EXP_W = $clog2(DIN_W);
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, flush = 1'b0;
  logic [LANES-1:0][DIN_W-1:0] din_re = '0, din_im = '0;
  logic exp_valid, busy;
  logic [EXP_W-1:0] exp_out, exp_raw;
  logic [HD-1:0][EXP_W-1:0] exp_hist;
  logic [15:0] blk_cnt;

  fft_cbfp_exp_calc #(.DIN_W(DIN_W), .LANES(LANES), .BLOCK_BEATS(BB), .HIST_DEPTH(HD), .MAX_SHIFT(MS)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .din_re(din_re), .din_im(din_im),
    .exp_valid(exp_valid), .exp_out(exp_out), .exp_raw(exp_raw), .exp_hist(exp_hist),
    .blk_cnt(blk_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [BB-1:0][4:0] k; logic [4:0] raw; logic [4:0] out; } vec_t;
  typedef struct packed { logic [4:0] raw; logic [4:0] out; } exp_t;
  exp_t sb[$];
  int pulse_cyc[$];
  int hist_m[HD];
  int blk_m = 0, cyc = 0, n_tests = 0, n_fail = 0;
  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input int a, input int b, input int c, input int d, input int raw, input int out);
    vec_t v;
    v.k[0] = 5'(a); v.k[1] = 5'(b); v.k[2] = 5'(c); v.k[3] = 5'(d);
    v.raw = 5'(raw); v.out = 5'(out);
    return v;
  endfunction

  // sample with exactly k leading sign bits, random sign
  function automatic logic [DIN_W-1:0] val(input int k);
    logic [DIN_W-1:0] x;
    x = '0;
    if (k < DIN_W-1) x[DIN_W-2-k] = 1'b1;
    if ($urandom_range(0, 1) == 1) x = ~x;
    return x;
  endfunction

  task automatic load(input int k);
    int s;
    for (int l = 0; l < LANES; l++) begin
      din_re[l] = val($urandom_range(k, DIN_W-1));
      din_im[l] = val($urandom_range(k, DIN_W-1));
    end
    s = $urandom_range(0, 2*LANES-1);
    if (s < LANES) din_re[s] = val(k);
    else din_im[s-LANES] = val(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int k);
    load(k);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic push(input int raw, input int out);
    exp_t e;
    e.raw = 5'(raw); e.out = 5'(out);
    sb.push_back(e);
  endtask

  task automatic chk_reset_state();
    chk("rst_exp_valid", exp_valid, 0);
    chk("rst_exp_out", exp_out, 0);
    chk("rst_exp_raw", exp_raw, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < HD; i++) chk("rst_hist", exp_hist[i], 0);
  endtask

  // monitor: pop the scoreboard on every pulse and track history/count model
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (exp_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("exp_raw", exp_raw, e.raw);
        chk("exp_out", exp_out, e.out);
        for (int i = HD-1; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = e.out;
        blk_m++;
        chk("blk_cnt", blk_cnt, blk_m);
        for (int i = 0; i < HD; i++) chk("exp_hist", exp_hist[i], hist_m[i]);
      end
    end
  end

  initial begin
    int p0;
    for (int i = 0; i < HD; i++) hist_m[i] = 0;
    tbl[0] = mk(22, 22, 22, 22, 22, 12);
    tbl[1] = mk(21, 10, 21, 21, 10, 10);
    tbl[2] = mk(21, 21, 0, 21, 0, 0);
    tbl[3] = mk(22, 21, 22, 22, 21, 12);
    tbl[4] = mk(18, 17, 14, 13, 13, 12);
    tbl[5] = mk(3, 9, 15, 20, 3, 3);
    tbl[6] = mk(8, 7, 12, 22, 7, 7);
    tbl[7] = mk(13, 14, 12, 19, 12, 12);
    tbl[8] = mk(15, 5, 16, 17, 5, 5);
    tbl[9] = mk(9, 20, 11, 10, 9, 9);

    tick(); tick();
    chk_reset_state();
    rst = 1'b0;
    tick();

    // all-zero block: exact latency of the pulse
    push(22, 12);
    din_re = '0; din_im = '0;
    valid_in = 1'b1;
    repeat (BB) tick();
    valid_in = 1'b0;
    chk("lat_not_yet", exp_valid, 0);
    tick();
    chk("lat_pulse", exp_valid, 1);
    tick();
    chk("lat_one_cycle", exp_valid, 0);
    chk("zero_blk_cnt", blk_cnt, 1);

    // mixed blocks: one small sample among ones, then the most negative value
    push(10, 10);
    for (int j = 0; j < BB; j++) begin
      for (int l = 0; l < LANES; l++) begin din_re[l] = 23'd1; din_im[l] = 23'd1; end
      if (j == 1) din_im[5] = 23'h000800;
      valid_in = 1'b1; tick();
    end
    push(0, 0);
    for (int j = 0; j < BB; j++) begin
      for (int l = 0; l < LANES; l++) begin din_re[l] = 23'd1; din_im[l] = 23'd1; end
      if (j == 2) din_re[0] = 23'h400000;
      valid_in = 1'b1; tick();
    end
    valid_in = 1'b0;
    repeat (3) tick();

    // table blocks back-to-back, one pulse every BB cycles
    p0 = pulse_cyc.size();
    foreach (tbl[n]) begin
      push(tbl[n].raw, tbl[n].out);
      for (int j = 0; j < BB; j++) beat(tbl[n].k[j]);
    end
    repeat (3) tick();
    chk("tbl_pulses", pulse_cyc.size() - p0, 10);
    for (int n = p0 + 1; n < pulse_cyc.size(); n++) chk("pulse_spacing", pulse_cyc[n] - pulse_cyc[n-1], BB);
    chk("hist0", exp_hist[0], 9);
    chk("hist1", exp_hist[1], 5);
    chk("hist2", exp_hist[2], 12);
    chk("hist3", exp_hist[3], 7);

    // valid_in gaps: exponent unaffected, busy held through idles
    push(6, 6);
    for (int j = 0; j < BB; j++) begin
      beat(j == 0 ? 14 : j == 1 ? 6 : j == 2 ? 11 : 19);
      if (j < BB-1) begin
        chk("gap_busy", busy, 1);
        repeat ($urandom_range(1, 3)) begin tick(); chk("gap_busy", busy, 1); end
      end
    end
    chk("gap_busy_end", busy, 0);
    repeat (3) tick();

    // flush together with beat 3: partial block dropped, fresh block follows
    beat(4); beat(4);
    load(2); valid_in = 1'b1; flush = 1'b1;
    tick();
    valid_in = 1'b0; flush = 1'b0;
    chk("flush_busy", busy, 0);
    beat(17); beat(16); beat(18);
    tick(); tick();
    chk("flush_hist_held", exp_hist[0], hist_m[0]);
    chk("flush_blk_held", blk_cnt, blk_m);
    push(16, 12);
    beat(20);
    repeat (3) tick();

    // flush while the last beat sits in stage 1: block discarded
    for (int j = 0; j < BB; j++) beat(1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    chk("flush_s1_blk", blk_cnt, blk_m);
    chk("flush_s1_raw", exp_raw, 16);

    // asynchronous reset mid-block clears everything immediately
    beat(3); beat(3);
    #2 rst = 1'b1;
    #1 chk_reset_state();
    sb.delete();
    blk_m = 0;
    for (int i = 0; i < HD; i++) hist_m[i] = 0;
    tick();
    rst = 1'b0;
    push(8, 8);
    beat(9); beat(8); beat(22); beat(10);
    repeat (3) tick();
    chk("post_rst_blk", blk_cnt, 1);

    repeat (4) tick();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
